key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream conditioning stage for the 12-key piano keyboard.
- Synchronises the raw, bouncy key switch inputs to the system clock and debounces each key independently.
- Produces a clean 12-bit stable key vector for the downstream ones-counter and note logic.
- Also produces one-cycle press and release pulses per key, plus a change strobe.

Parameters:
- NUM_KEYS, 12, number of keys; the downstream ones-counter is sized for 12.
- TICK_DIV, 50000, clock cycles per debounce sample tick; legal range 1 or more (1 ms at 50 MHz).
- STABLE_TICKS, 10, consecutive ticks a synchronised key must differ from its stable value before the change is accepted; legal range 1 or more.
- TICK_W, 16, prescaler counter width; must hold TICK_DIV-1.
- CNT_W, 4, per-key tick counter width; must hold STABLE_TICKS-1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- keys_raw  in  NUM_KEYS  asynchronous raw key levels, 1 = pressed.
- keys_stable  out  NUM_KEYS  debounced key vector.
- key_press  out  NUM_KEYS  one-cycle pulse per key on a stable 0->1 transition.
- key_release  out  NUM_KEYS  one-cycle pulse per key on a stable 1->0 transition.
- keys_changed  out  1  one-cycle pulse; equals OR of key_press and key_release.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. All state is sampled on the rising edge of clk while resetn=0.
- Reset values:
  - keys_stable, key_press, key_release = 0; keys_changed = 0.
  - Synchroniser flops, prescaler and all per-key counters = 0.
- Synchroniser: two flops per key, keys_raw -> s1 -> s2. Only s2 feeds the debounce logic.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is 1 for exactly the cycle in which the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is 1 every cycle.
- Per-key debounce; applies to key i each cycle:
  - s2[i] == keys_stable[i]: cnt[i] <= 0, no pulse. Any bounce back therefore restarts qualification.
  - s2[i] != keys_stable[i], tick=0: hold cnt[i].
  - s2[i] != keys_stable[i], tick=1, cnt[i] < STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
  - s2[i] != keys_stable[i], tick=1, cnt[i] == STABLE_TICKS-1: keys_stable[i] <= s2[i], cnt[i] <= 0, and the matching press or release pulse fires.
- Output timing:
  - Pulses are registered on the same edge that updates keys_stable. A pulse is high in the first cycle the new stable value is visible, then deasserts next cycle.
  - The same key never produces press and release in the same cycle.
  - Different keys may pulse simultaneously; keys_changed is then a single cycle high.
- Latency with TICK_DIV=1: a raw edge sampled at clock edge E0 appears on keys_stable after edge E0+1+STABLE_TICKS, i.e. 2+STABLE_TICKS edges.
  - With TICK_DIV>1, add up to one tick period of phase uncertainty per qualifying tick.
- Keys are fully independent; no key-to-key interaction.
- Reset mid-operation clears everything, with no pulses emitted in the reset cycle or the cycle after. Keys still held after reset are re-qualified from 0 and then produce normal press pulses.
- keys_stable changes at most once per qualification window per key, so glitches shorter than STABLE_TICKS ticks never reach the output.

Decomposition:
- Shared piano package holds:
  - NUM_KEYS = 12.
  - Default TICK_DIV and STABLE_TICKS constants, so the ones-counter and note logic use the same key width.
- One natural sub-module, key_debounce_cell: a single key's synchroniser, tick counter, stable flop and press/release pulse logic.
  - Instantiated NUM_KEYS times via generate.
  - The prescaler stays in the top level, with tick shared by all cells.

Test Plan:
1. Reset hold: keys_raw=12'hFFF during resetn=0 for 5 cycles -> all outputs 0. After release (TICK_DIV=1, STABLE_TICKS=4), keys_stable=12'hFFF and key_press=12'hFFF for one cycle exactly 6 edges later.
2. Clean press/release, TICK_DIV=1, STABLE_TICKS=4: keys_raw[3] 0->1 -> keys_stable=12'h008 after 6 edges, key_press=12'h008 and keys_changed=1 for one cycle. Then keys_raw[3] 1->0 -> key_release=12'h008 after 6 edges, keys_stable=0.
3. Bounce rejection: keys_raw[0] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no output change during toggling; a single key_press[0] pulse 6 edges after the final rise.
4. Prescaler timing, TICK_DIV=5, STABLE_TICKS=3: hold keys_raw[11]=1 -> keys_stable[11] rises on the third tick after s2 changes, between 12 and 17 edges after sampling. tick asserts every 5th cycle.
5. Simultaneous events: keys_raw 12'h0F0 -> 12'h00F in one cycle -> key_press=12'h00F, key_release=12'h0F0 and keys_changed=1, all in the same single cycle.
6. Mid-qualification reset: assert resetn=0 for 1 cycle when cnt=2 of 4 -> outputs 0. Full 6-edge latency restarts from the reset release.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Constants shared by the keyboard front end. The ones-counter and note logic
// use the same key width and debounce defaults.
package key_debounce_pkg;

  localparam int PIANO_KEYS           = 12;
  localparam int DEF_TICK_DIV         = 50000;
  localparam int DEF_STABLE_TICKS     = 10;
  localparam int DEF_TICK_W           = 16;
  localparam int DEF_CNT_W            = 4;

  // Result of a single key's qualification step in one clock cycle.
  typedef enum logic [1:0] {
    KEY_EDGE_NONE    = 2'd0,
    KEY_EDGE_PRESS   = 2'd1,
    KEY_EDGE_RELEASE = 2'd2
  } key_edge_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchroniser, tick-qualified change counter, stable flop
// and registered press/release pulses.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_raw,
  input  logic tick,
  output logic key_stable,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             press_reg;
  logic             release_reg;
  key_edge_t        key_edge_next;

  // Any cycle where the synchronised level agrees with the stable value
  // restarts qualification, so bounces never accumulate toward a change.
  always_comb begin
    cnt_next      = cnt_reg;
    stable_next   = stable_reg;
    key_edge_next = KEY_EDGE_NONE;
    if (sync2_reg == stable_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next   = sync2_reg;
        cnt_next      = '0;
        key_edge_next = sync2_reg ? KEY_EDGE_PRESS : KEY_EDGE_RELEASE;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      stable_reg  <= 1'b0;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= key_raw;
      sync2_reg   <= sync1_reg;
      stable_reg  <= stable_next;
      cnt_reg     <= cnt_next;
      press_reg   <= (key_edge_next == KEY_EDGE_PRESS);
      release_reg <= (key_edge_next == KEY_EDGE_RELEASE);
    end
  end

  assign key_stable  = stable_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_debounce.sv
// Keyboard input conditioning: shared sample-tick prescaler feeding one
// debounce cell per key, plus a combined change strobe.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS     = PIANO_KEYS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int TICK_W       = DEF_TICK_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_stable,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                keys_changed
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] presc_reg;
  logic [TICK_W-1:0] presc_next;
  logic              tick;

  // With TICK_DIV=1 the count sits at 0 and tick is high every cycle.
  assign tick = (presc_reg == TICK_LAST);

  always_comb begin
    presc_next = presc_reg + 1'b1;
    if (tick) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce_cell #(
        .STABLE_TICKS (STABLE_TICKS),
        .CNT_W        (CNT_W)
      ) u_cell (
        .clk         (clk),
        .resetn      (resetn),
        .key_raw     (keys_raw[gi]),
        .tick        (tick),
        .key_stable  (keys_stable[gi]),
        .key_press   (key_press[gi]),
        .key_release (key_release[gi])
      );
    end
  endgenerate

  // Pulses are already registered, so the OR is a clean one-cycle strobe.
  assign keys_changed = |(key_press | key_release);

endmodule

// File: tb/tb_key_debounce.sv
// Checks two key_debounce instances (TICK_DIV=1/STABLE_TICKS=4 and
// TICK_DIV=5/STABLE_TICKS=3) against a tick-counting reference model.
module tb_key_debounce;

  localparam int NK   = 12;
  localparam int TD_A = 1;
  localparam int ST_A = 4;
  localparam int TD_B = 5;
  localparam int ST_B = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NK-1:0] keys_raw = '0;

  logic [NK-1:0] stable_a, press_a, release_a;
  logic [NK-1:0] stable_b, press_b, release_b;
  logic          changed_a, changed_b;

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS(NK), .TICK_DIV(TD_A), .STABLE_TICKS(ST_A), .TICK_W(16), .CNT_W(4)
  ) dut_a (
    .clk(clk), .resetn(resetn), .keys_raw(keys_raw),
    .keys_stable(stable_a), .key_press(press_a), .key_release(release_a),
    .keys_changed(changed_a)
  );

  key_debounce #(
    .NUM_KEYS(NK), .TICK_DIV(TD_B), .STABLE_TICKS(ST_B), .TICK_W(16), .CNT_W(4)
  ) dut_b (
    .clk(clk), .resetn(resetn), .keys_raw(keys_raw),
    .keys_stable(stable_b), .key_press(press_b), .key_release(release_b),
    .keys_changed(changed_b)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  // cyc counts cycles since reset release; the shared tick is high in cycle c
  // exactly when c mod TICK_DIV == TICK_DIV-1.
  logic [NK-1:0] m_stable [2];
  logic [NK-1:0] m_press  [2];
  logic [NK-1:0] m_rel    [2];
  logic [NK-1:0] m_raw_d1 [2];
  logic [NK-1:0] m_raw_d2 [2];
  logic [NK-1:0] m_diff   [2];
  int            m_since  [2][NK];
  int            m_cyc    [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of tick cycles in the inclusive cycle range [a, b].
  function automatic int ticks_between(input int a, input int b, input int td);
    return (b + 1) / td - a / td;
  endfunction

  // Predict what the next rising edge produces, given this cycle's inputs.
  task automatic model_step(input int m, input int td, input int st,
                            input logic rst_n, input logic [NK-1:0] raw);
    logic [NK-1:0] s2;
    logic          tick;
    m_press[m] = '0;
    m_rel[m]   = '0;
    if (!rst_n) begin
      m_stable[m] = '0;
      m_raw_d1[m] = '0;
      m_raw_d2[m] = '0;
      m_diff[m]   = '0;
      m_cyc[m]    = 0;
      return;
    end
    s2   = m_raw_d2[m];
    tick = ((m_cyc[m] % td) == td - 1);
    for (int k = 0; k < NK; k++) begin
      if (s2[k] == m_stable[m][k]) begin
        m_diff[m][k] = 1'b0;
      end else begin
        if (!m_diff[m][k]) begin
          m_diff[m][k]  = 1'b1;
          m_since[m][k] = m_cyc[m];
        end
        if (tick && ticks_between(m_since[m][k], m_cyc[m], td) == st) begin
          m_stable[m][k] = s2[k];
          m_diff[m][k]   = 1'b0;
          if (s2[k]) m_press[m][k] = 1'b1;
          else       m_rel[m][k]   = 1'b1;
        end
      end
    end
    m_raw_d2[m] = m_raw_d1[m];
    m_raw_d1[m] = raw;
    m_cyc[m]++;
  endtask

  task automatic compare_all();
    check_val("a_stable",  32'(stable_a),  32'(m_stable[0]));
    check_val("a_press",   32'(press_a),   32'(m_press[0]));
    check_val("a_release", 32'(release_a), 32'(m_rel[0]));
    check_val("a_changed", 32'(changed_a), 32'(|(m_press[0] | m_rel[0])));
    check_val("b_stable",  32'(stable_b),  32'(m_stable[1]));
    check_val("b_press",   32'(press_b),   32'(m_press[1]));
    check_val("b_release", 32'(release_b), 32'(m_rel[1]));
    check_val("b_changed", 32'(changed_b), 32'(|(m_press[1] | m_rel[1])));
  endtask

  // Called just after a falling edge: drive one cycle, then check the result.
  task automatic apply(input logic rst_n, input logic [NK-1:0] raw);
    resetn   = rst_n;
    keys_raw = raw;
    model_step(0, TD_A, ST_A, rst_n, raw);
    model_step(1, TD_B, ST_B, rst_n, raw);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [NK-1:0] raw, input int cycles);
    for (int i = 0; i < cycles; i++) apply(1'b1, raw);
  endtask

  initial begin
    logic [NK-1:0] cur;
    logic [NK-1:0] glitch;
    @(negedge clk);

    // Reset with all keys held, then release: both instances must qualify FFF.
    for (int i = 0; i < 5; i++) apply(1'b0, 12'hFFF);
    hold(12'hFFF, 25);

    // Clean press and release of key 3.
    hold(12'h000, 25);
    hold(12'h008, 25);
    hold(12'h000, 25);

    // Bounce on key 0 then a settled press.
    for (int r = 0; r < 2; r++) begin
      hold(12'h001, 2);
      hold(12'h000, 2);
    end
    hold(12'h001, 25);
    hold(12'h000, 25);

    // Simultaneous press and release in the same cycle.
    hold(12'h0F0, 25);
    hold(12'h00F, 25);

    // Reset in the middle of a qualification window, keys still held.
    hold(12'h808, 4);
    apply(1'b0, 12'h808);
    hold(12'h808, 25);

    // Randomized phases: settled levels, short glitches, occasional reset.
    cur = 12'h808;
    for (int p = 0; p < 150; p++) begin
      case ($urandom_range(0, 9))
        0: begin
          apply(1'b0, cur);
        end
        1, 2, 3: begin
          glitch = NK'($urandom);
          hold(cur ^ glitch, $urandom_range(1, 3));
        end
        default: begin
          cur = NK'($urandom);
          hold(cur, $urandom_range(3, 30));
        end
      endcase
    end
    hold(cur, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Safety net so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
